// File: rtl/ysyx_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_ifu -- instruction fetch unit
//
// Takes a fetch PC from the PC stage and issues one read on a valid/ready
// memory port. It returns the fetched word and its PC to the decode stage on
// a valid/ready handshake. Only one transaction is outstanding at a time, so
// there is no prefetch. A flush discards in-flight or held work. A misaligned
// PC or a bus error produces a NOP with a non-zero cause code.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   fetch PC handshake (in_ready is combinational)
//   in_pc               fetch address
//   flush               redirect: drop in-flight and held work
//   mem_req_*           read request channel (registered valid/addr)
//   mem_rsp_*           read response channel (data + bus error)
//   out_valid/out_ready instruction handshake towards the IDU (registered)
//   out_inst/out_pc     fetched word and its address
//   out_cause           0 none, 1 misaligned PC, 2 bus error
//   fetch_count         number of output handshakes, wraps modulo 2^32
// ---------------------------------------------------------------------------
module ysyx_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [1:0]  out_cause,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUS      = 2'd2;

    logic [1:0] state_r;
    logic       drop_r;
    logic       in_fire_s;
    logic       out_fire_s;
    logic       pc_aligned_s;
    logic       rsp_drop_s;

    // Accept a new PC when idle, or when the held instruction leaves this
    // cycle; never during a flush or while a discarded response is pending.
    always_comb begin
        in_ready = 1'b0;
        if (!flush && !drop_r) begin
            if (state_r == ST_IDLE) begin
                in_ready = 1'b1;
            end else if (state_r == ST_HOLD) begin
                in_ready = out_ready;
            end else begin
                in_ready = 1'b0;
            end
        end else begin
            in_ready = 1'b0;
        end
    end

    assign in_fire_s    = in_valid && in_ready;
    assign out_fire_s   = out_valid && out_ready;
    assign pc_aligned_s = (in_pc[1:0] == 2'b00);
    // A flush that lands in the same cycle as the response also discards it.
    assign rsp_drop_s   = drop_r || flush;

    // Fetch FSM, request/response registers and handshake counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            drop_r        <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= 32'h0000_0000;
            out_valid     <= 1'b0;
            out_inst      <= 32'h0000_0000;
            out_pc        <= RESET_PC;
            out_cause     <= CAUSE_NONE;
            fetch_count   <= 32'h0000_0000;
        end else begin
            if (out_fire_s) begin
                fetch_count <= fetch_count + 32'd1;
            end

            case (state_r)
                ST_IDLE: begin
                    // A new fetch is launched by the common block below.
                end
                ST_REQ: begin
                    // A request that is already on the bus cannot be
                    // withdrawn, so a flush only marks its response as stale.
                    if (flush) begin
                        drop_r <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_r       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (rsp_drop_s) begin
                            drop_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            out_valid <= 1'b1;
                            out_inst  <= mem_rsp_err ? NOP_INST : mem_rsp_data;
                            out_cause <= mem_rsp_err ? CAUSE_BUS : CAUSE_NONE;
                            out_pc    <= mem_req_addr;
                            state_r   <= ST_HOLD;
                        end
                    end else if (flush) begin
                        drop_r <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A flush retires the held word. A handshake in the same
                    // cycle is still counted above.
                    if (flush || out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    drop_r        <= 1'b0;
                    mem_req_valid <= 1'b0;
                    out_valid     <= 1'b0;
                end
            endcase

            // Launch a new fetch. This overrides the HOLD->IDLE exit above when
            // a new PC arrives in the same cycle as the output handshake.
            if (in_fire_s) begin
                if (pc_aligned_s) begin
                    mem_req_valid <= 1'b1;
                    mem_req_addr  <= in_pc;
                    state_r       <= ST_REQ;
                end else begin
                    out_valid <= 1'b1;
                    out_inst  <= NOP_INST;
                    out_pc    <= in_pc;
                    out_cause <= CAUSE_MISALIGN;
                    state_r   <= ST_HOLD;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_ifu -- self-checking bench for ysyx_ifu
//
// Directed scenarios are followed by randomized fetches. Expected values come
// from a small memory model (mem_word) and the fetch rules: aligned PCs read
// memory, misaligned PCs and bus errors yield a NOP with a cause code, and
// every output handshake adds one to the count.
// ---------------------------------------------------------------------------
module tb_ysyx_ifu;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] RST_PC  = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [1:0]  out_cause;
    logic [31:0] fetch_count;

    int          tests;
    int          fails;
    logic [31:0] exp_count;

    ysyx_ifu dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_cause     (out_cause),
        .fetch_count   (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents model: arbitrary but deterministic per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0010_0093;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".req_valid"}, {31'd0, mem_req_valid}, 32'd0);
        check({tag, ".req_addr"},  mem_req_addr, 32'd0);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".out_inst"},  out_inst, 32'd0);
        check({tag, ".out_pc"},    out_pc, RST_PC);
        check({tag, ".out_cause"}, {30'd0, out_cause}, 32'd0);
        check({tag, ".count"},     fetch_count, 32'd0);
    endtask

    // One full fetch, starting from IDLE, with chosen memory/consumer delays.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input bit err,
                         input int req_d, input int rsp_d, input int out_d);
        logic [31:0] e_inst;
        logic [1:0]  e_cause;
        in_valid = 1'b1;
        in_pc    = pc;
        #1;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_pc    = $urandom;
        if (pc[1:0] == 2'b00) begin
            check("req_valid", {31'd0, mem_req_valid}, 32'd1);
            check("req_addr", mem_req_addr, pc);
            check("out_valid_req", {31'd0, out_valid}, 32'd0);
            for (int i = 0; i < req_d; i++) begin
                mem_req_ready = 1'b0;
                step();
                check("req_valid_stall", {31'd0, mem_req_valid}, 32'd1);
                check("req_addr_stall", mem_req_addr, pc);
            end
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            check("req_valid_drop", {31'd0, mem_req_valid}, 32'd0);
            check("out_valid_wait", {31'd0, out_valid}, 32'd0);
            for (int i = 0; i < rsp_d; i++) begin
                step();
                check("req_once", {31'd0, mem_req_valid}, 32'd0);
                check("out_valid_wait", {31'd0, out_valid}, 32'd0);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = data;
            mem_rsp_err   = err;
            step();
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
            mem_rsp_data  = $urandom;
            e_inst  = err ? NOP : data;
            e_cause = err ? 2'd2 : 2'd0;
        end else begin
            check("misaligned_no_req", {31'd0, mem_req_valid}, 32'd0);
            e_inst  = NOP;
            e_cause = 2'd1;
        end
        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("out_inst", out_inst, e_inst);
        check("out_pc", out_pc, pc);
        check("out_cause", {30'd0, out_cause}, {30'd0, e_cause});
        for (int i = 0; i < out_d; i++) begin
            out_ready = 1'b0;
            step();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_inst", out_inst, e_inst);
            check("hold_pc", out_pc, pc);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count = exp_count + 32'd1;
        check("out_valid_done", {31'd0, out_valid}, 32'd0);
        check("fetch_count", fetch_count, exp_count);
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        exp_count     = 32'd0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_pc         = 32'd0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        mem_rsp_err   = 1'b0;
        out_ready     = 1'b0;

        // Reset state.
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        step();

        // Best-case fetch, stalled request, misaligned PC, bus error.
        fetch(32'h8000_0000, 32'h0010_0093, 1'b0, 0, 0, 0);
        fetch(32'h8000_0008, mem_word(32'h8000_0008), 1'b0, 4, 0, 0);
        fetch(32'h8000_0002, 32'd0, 1'b0, 0, 0, 0);
        fetch(32'h8000_0010, 32'h1234_5678, 1'b1, 1, 1, 1);

        // Flush in REQ and again in WAIT: the response must be discarded.
        in_valid = 1'b1;
        in_pc    = 32'h8000_0100;
        step();
        in_valid      = 1'b0;
        mem_req_ready = 1'b0;
        flush         = 1'b1;
        in_valid      = 1'b1;
        #1;
        check("flush_req_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_req_kept", {31'd0, mem_req_valid}, 32'd1);
        check("flush_req_addr", mem_req_addr, 32'h8000_0100);
        #1;
        check("drop_in_ready", {31'd0, in_ready}, 32'd0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("flush_req_accepted", {31'd0, mem_req_valid}, 32'd0);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b1;
        #1;
        check("drop_wait_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("drop_wait_in_ready2", {31'd0, in_ready}, 32'd0);
        in_valid      = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        step();
        mem_rsp_valid = 1'b0;
        check("drop_no_out", {31'd0, out_valid}, 32'd0);
        check("drop_inst_kept", out_inst, NOP);
        check("drop_count", fetch_count, exp_count);
        check("drop_no_req", {31'd0, mem_req_valid}, 32'd0);
        #1;
        check("drop_idle_ready", {31'd0, in_ready}, 32'd1);

        // Flush in HOLD together with a consume and a new PC: count, no fetch.
        in_valid = 1'b1;
        in_pc    = 32'h8000_0021;
        step();
        check("hold_flush_setup", {31'd0, out_valid}, 32'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_pc     = 32'h8000_0040;
        #1;
        check("hold_flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_count = exp_count + 32'd1;
        check("hold_flush_valid", {31'd0, out_valid}, 32'd0);
        check("hold_flush_no_req", {31'd0, mem_req_valid}, 32'd0);
        check("hold_flush_count", fetch_count, exp_count);

        // Stall in HOLD, then consume together with a new PC.
        in_valid = 1'b1;
        in_pc    = 32'h8000_0003;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_pc", out_pc, 32'h8000_0003);
            check("stall_cause", {30'd0, out_cause}, 32'd1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h8000_0004;
        #1;
        check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_count = exp_count + 32'd1;
        check("b2b_out_valid", {31'd0, out_valid}, 32'd0);
        check("b2b_req_valid", {31'd0, mem_req_valid}, 32'd1);
        check("b2b_req_addr", mem_req_addr, 32'h8000_0004);
        check("b2b_count", fetch_count, exp_count);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();

        // Asynchronous reset pulse mid-WAIT.
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        #1;
        rst       = 1'b0;
        exp_count = 32'd0;
        step();

        // Randomized fetches.
        for (int n = 0; n < 25; n++) begin
            logic [31:0] pc;
            pc = {$urandom} & 32'hFFFF_FFF0;
            pc = pc | 32'h8000_0000;
            if ($urandom_range(3, 0) == 0) begin
                pc[1:0] = 2'($urandom_range(3, 1));
            end else begin
                pc[3:2] = 2'($urandom_range(3, 0));
            end
            fetch(pc, mem_word(pc), ($urandom_range(7, 0) == 0),
                  int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                  int'($urandom_range(3, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
